mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MIPS MEM stage between EX/MEM register and MEM2WB. Runs lb/lbu/lh/lhu/lw/sb/sh/sw over a
//  req/ack data-memory bus, stalls the pipeline while a transfer is outstanding and aligns /
//  extends load data. Passes WB-bound control through to MEM2WB.
// PARAMETERS
//  TIMEOUT  16  cycles in REQ without dmem_ack before abort with bus_err (>=1)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous reset, active-low
//  mem_read_in      in   1   load op
//  mem_write_in     in   1   store op (wins if mem_read_in also set)
//  mem_size_in      in   2   00 byte, 01 half, 10 word (11 treated as word)
//  mem_unsigned_in  in   1   zero-extend loads (lbu/lhu)
//  AluResIn         in   32  effective address / ALU result
//  store_data_in    in   32  rt value for stores
//  write_reg_in     in   5   dest reg;  MemtoRegIn in 1;  DatacIn in 1 (reg write enable)
//  pc_in            in   32  instruction PC
//  write_reg_out, AluResOut, MemtoRegOut, DatacOut, pc_out  out  5/32/1/1/32  to MEM2WB
//  read_data_out    out  32  aligned, extended load data
//  stall_out        out  1   freeze PC, IF/ID, ID/EX, EX/MEM
//  misalign_err     out  1   misaligned access this cycle
//  bus_err          out  1   one-cycle pulse on timeout abort
//  dmem_req/dmem_we out  1   bus request / write strobe
//  dmem_addr        out  32  word address {AluResIn[31:2],2'b00}
//  dmem_wdata       out  32  lane-replicated store data;  dmem_be out 4 byte enables
//  dmem_ack         in   1   transfer complete;  dmem_rdata in 32 read word
// BEHAVIOUR
//  - rst low (any time, incl. mid-transfer): state IDLE, timeout counter 0, rdata_q 0; all dmem_*,
//    stall_out, misalign_err, bus_err, read_data_out = 0; write_reg_out, DatacOut, MemtoRegOut = 0.
//  - States: IDLE, REQ, DONE.
//  - IDLE: no mem op -> stall_out 0, pass-through of all *_in, zero added latency.
//    Aligned mem op -> stall_out 1, latch addr/be/wdata/we, next state REQ.
//    Misaligned (half: addr[0]; word: addr[1:0]!=0) -> no request, misalign_err 1 that cycle,
//    stall_out 0, DatacOut and write_reg_out forced 0.
//  - REQ: dmem_req 1, dmem_* from latches, stall_out 1. dmem_ack -> load data into rdata_q, go DONE.
//    Counter increments each REQ cycle; reaching TIMEOUT without ack -> rdata_q 0, bus_err pulse
//    in DONE, DatacOut 0 in DONE. Ack in the timeout cycle counts as success.
//  - DONE: dmem_req 0, stall_out 0, read_data_out = rdata_q, counter cleared, next IDLE.
//    Mem op occupies 3 cycles min (ack in first REQ cycle); MEM2WB captures at end of DONE.
//  - dmem_ack outside REQ ignored. Inputs held stable by stall; not re-sampled in REQ/DONE.
//  - Stores: sb be=4'b0001<<addr[1:0], wdata={4{b}}; sh be=addr[1]?1100:0011, wdata={2{h}};
//    sw be=1111. Loads: lane by addr[1:0] (byte) or addr[1] (half), sign-extend unless
//    mem_unsigned_in. read_data_out 0 outside DONE.
//  - Pass-through (write_reg, AluRes, MemtoReg, Datac, pc) combinational except forcing above.
// TESTING
//  1 lw addr 0x100, ack 1st REQ cycle, rdata 0xDEADBEEF -> stall 1,1,0; read_data_out 0xDEADBEEF
//    in DONE; dmem_be 1111, dmem_addr 0x100.
//  2 lb addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; lbu -> 0x00000080; lh 0x102 -> 0xFFFF8011.
//  3 sh addr 0x106, store 0x0000ABCD -> be 1100, wdata 0xABCDABCD, we 1, addr 0x104.
//  4 lw addr 0x101 -> misalign_err 1, no dmem_req, stall 0, DatacOut 0, write_reg_out 0.
//  5 ack withheld, TIMEOUT=16 -> 16 REQ cycles, bus_err pulse, read_data_out 0, DatacOut 0, IDLE.
//  6 rst low 2nd REQ cycle -> dmem_req 0 at once, IDLE; later ack ignored; next op starts clean.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
// The stage drives a request with a word address, byte enables, write strobe
// and lane-replicated write data; the memory answers with an ack and, for
// reads, the full 32-bit word.
//   dmem_req    stage -> mem  transfer request, held until ack or abort
//   dmem_we     stage -> mem  write strobe (store)
//   dmem_addr   stage -> mem  word-aligned byte address
//   dmem_wdata  stage -> mem  store data replicated across lanes
//   dmem_be     stage -> mem  byte enables
//   dmem_ack    mem -> stage  transfer complete
//   dmem_rdata  mem -> stage  read word, valid with dmem_ack
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage sitting between the EX/MEM and MEM2WB registers.
// Executes lb/lbu/lh/lhu/lw/sb/sh/sw over a req/ack data bus, freezes the
// front of the pipeline while a transfer is outstanding, and aligns and
// extends load data. WB-bound control passes straight through to MEM2WB.
// Ports:
//   clk, rst (async, active-low)
//   mem_read_in/mem_write_in/mem_size_in/mem_unsigned_in  access decode
//   AluResIn, store_data_in, write_reg_in, MemtoRegIn, DatacIn, pc_in
//   write_reg_out, AluResOut, MemtoRegOut, DatacOut, pc_out   to MEM2WB
//   read_data_out  aligned/extended load data, valid in DONE only
//   stall_out      freeze PC, IF/ID, ID/EX, EX/MEM
//   misalign_err   misaligned access detected this cycle
//   bus_err        one-cycle pulse when a transfer is aborted on timeout
//   dmem           data-memory bus (master side)
// Every memory op takes IDLE -> REQ (one or more cycles) -> DONE, so at
// least three cycles; MEM2WB captures the result at the end of DONE.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic [31:0] AluResIn,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  write_reg_in,
    input  logic        MemtoRegIn,
    input  logic        DatacIn,
    input  logic [31:0] pc_in,
    output logic [4:0]  write_reg_out,
    output logic [31:0] AluResOut,
    output logic        MemtoRegOut,
    output logic        DatacOut,
    output logic [31:0] pc_out,
    output logic [31:0] read_data_out,
    output logic        stall_out,
    output logic        misalign_err,
    output logic        bus_err,
    mem_access_stage_if.master dmem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic [1:0]         off_q, off_d;
    logic               tmo_q, tmo_d;

    logic [1:0]         eff_size;
    logic               mem_op;
    logic               misaligned;
    logic               start;
    logic [3:0]         be_calc;
    logic [31:0]        wdata_calc;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_val;
    logic               in_req;
    logic               in_done;

    // Decode the incoming access: size 11 behaves as a word, a store wins
    // over a load, and misaligned half/word accesses never reach the bus.
    always_comb begin
        eff_size   = (mem_size_in == 2'b11) ? 2'b10 : mem_size_in;
        mem_op     = mem_read_in | mem_write_in;
        misaligned = ((eff_size == 2'b01) && AluResIn[0]) ||
                     ((eff_size == 2'b10) && (AluResIn[1:0] != 2'b00));
        start      = (state_q == IDLE) && mem_op && !misaligned;
        be_calc    = 4'b1111;
        wdata_calc = store_data_in;
        case (eff_size)
            2'b00: begin
                be_calc    = 4'b0001 << AluResIn[1:0];
                wdata_calc = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                be_calc    = AluResIn[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{store_data_in[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = store_data_in;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it, using
    // the access shape captured when the request started.
    always_comb begin
        byte_sel = dmem.dmem_rdata[7:0];
        case (off_q)
            2'd0:    byte_sel = dmem.dmem_rdata[7:0];
            2'd1:    byte_sel = dmem.dmem_rdata[15:8];
            2'd2:    byte_sel = dmem.dmem_rdata[23:16];
            default: byte_sel = dmem.dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_val = dmem.dmem_rdata;
        endcase
    end

    // Transfer sequencing. The counter tracks REQ cycles; when the last
    // allowed cycle passes without ack the transfer is abandoned with zero
    // data. An ack in that last cycle still counts as success.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        off_d      = off_q;
        tmo_d      = tmo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = {AluResIn[31:2], 2'b00};
                    be_d       = be_calc;
                    wdata_d    = wdata_calc;
                    we_d       = mem_write_in;
                    size_d     = eff_size;
                    unsigned_d = mem_unsigned_in;
                    off_d      = AluResIn[1:0];
                    cnt_d      = '0;
                    tmo_d      = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (dmem.dmem_ack) begin
                    rdata_d = load_val;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                tmo_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            off_q      <= 2'b00;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            off_q      <= off_d;
            tmo_q      <= tmo_d;
        end
    end

    // Bus fields come only from the captured request and are zero outside REQ.
    // Stage outputs that depend on live inputs are masked while rst is low so
    // nothing leaks out during reset.
    always_comb begin
        in_req           = (state_q == REQ);
        in_done          = (state_q == DONE);
        dmem.dmem_req    = in_req;
        dmem.dmem_we     = in_req & we_q;
        dmem.dmem_addr   = in_req ? addr_q : 32'h0;
        dmem.dmem_be     = in_req ? be_q : 4'b0000;
        dmem.dmem_wdata  = in_req ? wdata_q : 32'h0;
        stall_out        = rst & (start | in_req);
        misalign_err     = rst & (state_q == IDLE) & mem_op & misaligned;
        bus_err          = in_done & tmo_q;
        read_data_out    = in_done ? rdata_q : 32'h0;
        AluResOut        = AluResIn;
        pc_out           = pc_in;
        MemtoRegOut      = rst & MemtoRegIn;
        write_reg_out    = (rst && !misalign_err) ? write_reg_in : 5'd0;
        DatacOut         = rst & DatacIn & ~misalign_err & ~bus_err;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage. Stimulus issues one access at a time and
// pushes the expected outcome into a scoreboard queue; a monitor pops and
// compares whenever the stage finishes an access (end of stall) or flags a
// misalignment. A memory responder acks after a per-access delay, or never
// (timeout), and drives random ack noise whenever no request is pending.
module tb_mem_access_stage;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in, mem_write_in, mem_unsigned_in;
    logic [1:0]  mem_size_in;
    logic [31:0] AluResIn, store_data_in, pc_in;
    logic [4:0]  write_reg_in;
    logic        MemtoRegIn, DatacIn;
    logic [4:0]  write_reg_out;
    logic [31:0] AluResOut, pc_out, read_data_out;
    logic        MemtoRegOut, DatacOut, stall_out, misalign_err, bus_err;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .mem_size_in    (mem_size_in),
        .mem_unsigned_in(mem_unsigned_in),
        .AluResIn       (AluResIn),
        .store_data_in  (store_data_in),
        .write_reg_in   (write_reg_in),
        .MemtoRegIn     (MemtoRegIn),
        .DatacIn        (DatacIn),
        .pc_in          (pc_in),
        .write_reg_out  (write_reg_out),
        .AluResOut      (AluResOut),
        .MemtoRegOut    (MemtoRegOut),
        .DatacOut       (DatacOut),
        .pc_out         (pc_out),
        .read_data_out  (read_data_out),
        .stall_out      (stall_out),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err),
        .dmem           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mis;
        bit          is_load;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic        tmo;
        logic        datac;
        logic [4:0]  wreg;
        logic        memtoreg;
        logic [31:0] alu;
        logic [31:0] pc;
        int          req_cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cur_delay = 0;
    logic [31:0] cur_word = 32'h0;
    bit          hold_ack = 1'b0;
    bit          mon_en = 1'b0;
    int          req_cnt = 0;
    int          req_seen = 0;
    bit          prev_stall = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: ack after cur_delay REQ cycles (never if the delay
    // is beyond the timeout); random ack noise outside requests.
    always @(negedge clk) begin
        if (hold_ack) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = $urandom;
            req_cnt        = 0;
        end else if (bus.dmem_req) begin
            if (req_cnt == cur_delay) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = cur_word;
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = $urandom;
            end
            req_cnt++;
        end else begin
            bus.dmem_ack   = 1'($urandom_range(0, 1));
            bus.dmem_rdata = $urandom;
            req_cnt        = 0;
        end
    end

    // Monitor: checks bus fields on the first REQ cycle, pops the scoreboard
    // when an access completes or is rejected, and checks plain pass-through
    // on idle cycles.
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            prev_stall = 1'b0;
            req_seen   = 0;
        end else begin
            if (bus.dmem_req) begin
                if (req_seen == 0) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        checkOutput("bus_addr", bus.dmem_addr, sb_q[0].addr);
                        checkOutput("bus_be", 32'(bus.dmem_be), 32'(sb_q[0].be));
                        checkOutput("bus_we", 32'(bus.dmem_we), 32'(sb_q[0].we));
                        if (sb_q[0].we)
                            checkOutput("bus_wdata", bus.dmem_wdata, sb_q[0].wdata);
                    end
                end
                req_seen++;
            end
            if (misalign_err || (prev_stall && !stall_out)) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("kind_misaligned", 32'(misalign_err), 32'(e.is_mis));
                    checkOutput("wreg_out", 32'(write_reg_out), 32'(e.wreg));
                    checkOutput("datac_out", 32'(DatacOut), 32'(e.datac));
                    checkOutput("memtoreg_out", 32'(MemtoRegOut), 32'(e.memtoreg));
                    checkOutput("alu_out", AluResOut, e.alu);
                    checkOutput("pc_out", pc_out, e.pc);
                    if (e.is_mis) begin
                        checkOutput("mis_stall", 32'(stall_out), 32'd0);
                        checkOutput("mis_req", 32'(bus.dmem_req), 32'd0);
                        checkOutput("mis_bus_err", 32'(bus_err), 32'd0);
                    end else begin
                        checkOutput("req_cycles", 32'(req_seen), 32'(e.req_cycles));
                        checkOutput("bus_err", 32'(bus_err), 32'(e.tmo));
                        checkOutput("done_req", 32'(bus.dmem_req), 32'd0);
                        if (e.is_load)
                            checkOutput("read_data", read_data_out, e.rdata);
                    end
                end
                req_seen = 0;
            end else if (!stall_out) begin
                checkOutput("idle_read_data", read_data_out, 32'h0);
                checkOutput("idle_bus_err", 32'(bus_err), 32'd0);
                checkOutput("idle_req", 32'(bus.dmem_req), 32'd0);
                checkOutput("idle_wreg", 32'(write_reg_out), 32'(write_reg_in));
                checkOutput("idle_datac", 32'(DatacOut), 32'(DatacIn));
            end
            prev_stall = stall_out;
        end
    end

    // Issue one access and hold it until the stage releases the stall.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] sz,
                                 input bit uns, input logic [31:0] addr,
                                 input logic [31:0] sdata, input int delay,
                                 input logic [31:0] word);
        exp_t e;
        int   esz;
        int   off;
        int   v;
        bit   released;
        @(posedge clk);
        #1;
        mem_read_in     = rd;
        mem_write_in    = wr;
        mem_size_in     = sz;
        mem_unsigned_in = uns;
        AluResIn        = addr;
        store_data_in   = sdata;
        write_reg_in    = 5'($urandom_range(1, 31));
        DatacIn         = 1'($urandom_range(0, 1));
        MemtoRegIn      = 1'($urandom_range(0, 1));
        pc_in           = $urandom & 32'hFFFF_FFFC;
        cur_delay       = delay;
        cur_word        = word;
        if (!(rd || wr)) begin
            @(negedge clk);
            return;
        end
        esz          = (sz == 2'b11) ? 2 : int'(sz);
        off          = int'(addr[1:0]);
        e.is_mis     = (esz == 1 && (off % 2) != 0) || (esz == 2 && off != 0);
        e.is_load    = !wr;
        e.addr       = addr & 32'hFFFF_FFFC;
        e.we         = wr;
        e.tmo        = (delay >= TMO);
        e.req_cycles = e.tmo ? TMO : delay + 1;
        e.memtoreg   = MemtoRegIn;
        e.alu        = addr;
        e.pc         = pc_in;
        e.wreg       = e.is_mis ? 5'd0 : write_reg_in;
        e.datac      = (e.is_mis || e.tmo) ? 1'b0 : DatacIn;
        if (esz == 0) begin
            e.be    = 4'(1 << off);
            e.wdata = (sdata & 32'hFF) * 32'h0101_0101;
            v       = int'((word >> (8 * off)) & 32'hFF);
            if (!uns && v >= 128) v = v - 256;
            e.rdata = 32'(v);
        end else if (esz == 1) begin
            e.be    = (off >= 2) ? 4'hC : 4'h3;
            e.wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
            v       = int'((word >> (16 * (off / 2))) & 32'hFFFF);
            if (!uns && v >= 32768) v = v - 65536;
            e.rdata = 32'(v);
        end else begin
            e.be    = 4'hF;
            e.wdata = sdata;
            e.rdata = word;
        end
        if (e.tmo) e.rdata = 32'h0;
        sb_q.push_back(e);
        released = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_out) begin
                released = 1'b1;
                break;
            end
        end
        if (!released) begin
            checkOutput("stall_release", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    task automatic setNoOp();
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset with an aligned load presented: everything must stay quiet.
        rst             = 1'b0;
        mem_read_in     = 1'b1;
        mem_write_in    = 1'b0;
        mem_size_in     = 2'b10;
        mem_unsigned_in = 1'b0;
        AluResIn        = 32'h100;
        store_data_in   = 32'h0;
        write_reg_in    = 5'd9;
        MemtoRegIn      = 1'b1;
        DatacIn         = 1'b1;
        pc_in           = 32'h400;
        #2;
        checkOutput("rst_stall", 32'(stall_out), 32'd0);
        checkOutput("rst_req", 32'(bus.dmem_req), 32'd0);
        checkOutput("rst_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("rst_be", 32'(bus.dmem_be), 32'd0);
        checkOutput("rst_read_data", read_data_out, 32'h0);
        checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
        checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
        checkOutput("rst_wreg", 32'(write_reg_out), 32'd0);
        checkOutput("rst_datac", 32'(DatacOut), 32'd0);
        checkOutput("rst_memtoreg", 32'(MemtoRegOut), 32'd0);
        setNoOp();
        #20;
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Directed cases from the block's intended behaviour.
        applyStimulus(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        applyStimulus(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80112233);
        applyStimulus(1, 0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h80112233);
        applyStimulus(1, 0, 2'b01, 0, 32'h102, 32'h0, 2, 32'h80112233);
        applyStimulus(0, 1, 2'b01, 0, 32'h106, 32'h0000ABCD, 0, 32'h0);
        applyStimulus(0, 1, 2'b00, 0, 32'h109, 32'h123456F7, 1, 32'h0);
        applyStimulus(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0);
        applyStimulus(1, 1, 2'b11, 0, 32'h204, 32'hCAFEF00D, 0, 32'h0);
        applyStimulus(1, 0, 2'b10, 0, 32'h300, 32'h0, 99, 32'h11111111);
        applyStimulus(1, 0, 2'b10, 0, 32'h304, 32'h0, TMO - 1, 32'h5A5AA5A5);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 32'h0);

        // Randomized accesses.
        for (int n = 0; n < 80; n++) begin
            bit          rd, wr;
            int          d;
            logic [31:0] a;
            a  = $urandom;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) d = 99;
            else d = $urandom_range(0, 5);
            applyStimulus(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          a, $urandom, d, $urandom);
        end

        // Reset in the second REQ cycle, then stray acks while idle.
        @(posedge clk);
        #1;
        mon_en          = 1'b0;
        mem_read_in     = 1'b1;
        mem_write_in    = 1'b0;
        mem_size_in     = 2'b10;
        AluResIn        = 32'h200;
        write_reg_in    = 5'd7;
        DatacIn         = 1'b1;
        cur_delay       = 99;
        @(negedge clk);
        checkOutput("rst_pre_stall", 32'(stall_out), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_mid_req", 32'(bus.dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_req_drop", 32'(bus.dmem_req), 32'd0);
        checkOutput("rst_mid_stall", 32'(stall_out), 32'd0);
        checkOutput("rst_mid_datac", 32'(DatacOut), 32'd0);
        checkOutput("rst_mid_wreg", 32'(write_reg_out), 32'd0);
        setNoOp();
        hold_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post_rst_req", 32'(bus.dmem_req), 32'd0);
            checkOutput("post_rst_stall", 32'(stall_out), 32'd0);
            checkOutput("post_rst_read_data", read_data_out, 32'h0);
            checkOutput("post_rst_bus_err", 32'(bus_err), 32'd0);
        end
        hold_ack = 1'b0;
        mon_en   = 1'b1;
        applyStimulus(1, 0, 2'b01, 1, 32'h402, 32'h0, 2, 32'hF00DBEEF);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
